// File: rtl/fifo_rd_skid.sv
// Two-entry skid stage turning a first-word-fall-through FIFO read port into a valid/ready stream.
// Define FIFO_RD_SKID_STATS_EN to build the saturating stall_cnt statistic.
module fifo_rd_skid #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fifo_valid,
   input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
   output logic                   fifo_pop,
   output logic                   out_valid,
   output logic [DATA_WIDTH-1:0]  out_data,
   input  logic                   out_ready,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic                  enq, deq;

   // Pop depends only on our own occupancy, never on out_ready.
   assign fifo_pop  = fifo_valid & (state_q != StTwo) & ~rst;
   assign enq       = fifo_pop;
   assign out_valid = (state_q != StEmpty);
   assign deq       = out_valid & out_ready;
   assign out_data  = head_q;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      case (state_q)
         StEmpty: begin
            if (enq) begin
               state_d = StOne;
               head_d  = fifo_rd_data;
            end
         end
         StOne: begin
            if (enq && deq) begin
               head_d = fifo_rd_data;
            end else if (enq) begin
               state_d = StTwo;
               skid_d  = fifo_rd_data;
            end else if (deq) begin
               state_d = StEmpty;
            end
         end
         StTwo: begin
            if (deq) begin
               state_d = StOne;
               head_d  = skid_q;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StEmpty;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

`ifdef FIFO_RD_SKID_STATS_EN
   logic [STALL_CNT_W-1:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
         stall_q <= stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule
